// File: rtl/nf_rf_pkg.sv
// rtl/nf_rf_pkg.sv - shared defaults and state type for the multi-port register file
package nf_rf_pkg;

    localparam int NF_RF_XLEN     = 32;
    localparam int NF_RF_REG_NUM  = 32;
    localparam int NF_RF_RD_PORTS = 2;

    typedef enum logic {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

endpackage

// File: rtl/nf_rf_init_fsm.sv
// rtl/nf_rf_init_fsm.sv - post-reset clear sequencer; walks registers 1..REG_NUM-1 writing zero
module nf_rf_init_fsm
    import nf_rf_pkg::*;
#(
    parameter  int REG_NUM = NF_RF_REG_NUM,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          init_done
);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                // Register 0 is hardwired, so the walk starts at 1 and ends on the last register.
                if (cnt_q == AW'(REG_NUM - 1)) begin
                    state_d = RF_READY;
                end
            end
            RF_READY: begin
            end
        endcase
    end

    assign init_done = (state_q == RF_READY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RF_CLEAR;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/nf_reg_file_mp.sv
// rtl/nf_reg_file_mp.sv - 2W/NR register file with bypass and hardware clear
// Optional pending-register scoreboard enabled by NF_RF_SCOREBOARD_EN.
module nf_reg_file_mp
    import nf_rf_pkg::*;
#(
    parameter  int XLEN     = NF_RF_XLEN,
    parameter  int REG_NUM  = NF_RF_REG_NUM,
    parameter  int RD_PORTS = NF_RF_RD_PORTS,
    localparam int AW       = $clog2(REG_NUM)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [RD_PORTS*AW-1:0]   ra,
    output logic [RD_PORTS*XLEN-1:0] rd,
    input  logic [AW-1:0]            wa_a,
    input  logic [XLEN-1:0]          wd_a,
    input  logic                     we_a,
    input  logic [AW-1:0]            wa_b,
    input  logic [XLEN-1:0]          wd_b,
    input  logic                     we_b,
    output logic                     init_done
`ifdef NF_RF_SCOREBOARD_EN
    ,
    input  logic                     pend_set,
    input  logic [AW-1:0]            pend_addr,
    output logic [RD_PORTS-1:0]      rd_pend
`endif
);

    logic [XLEN-1:0] mem_q [REG_NUM];
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            wr_a_en;
    logic            wr_b_en;

    nf_rf_init_fsm #(
        .REG_NUM (REG_NUM)
    ) u_init_fsm (
        .clk       (clk),
        .resetn    (resetn),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    // Port B wins a same-address collision, so port A is dropped rather than overwritten.
    always_comb begin
        wr_b_en = init_done && we_b && (wa_b != '0);
        wr_a_en = init_done && we_a && (wa_a != '0) && !(we_b && (wa_b == wa_a));
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end
        if (wr_a_en) begin
            mem_q[wa_a] <= wd_a;
        end
        if (wr_b_en) begin
            mem_q[wa_b] <= wd_b;
        end
    end

`ifdef NF_RF_SCOREBOARD_EN
    logic [REG_NUM-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (wr_b_en) begin
            pend_d[wa_b] = 1'b0;
        end
        if (pend_set) begin
            pend_d[pend_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
        if (!init_done) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    always_comb begin : read_mux
        logic [AW-1:0] rd_addr;
        rd_addr = '0;
        rd      = '0;
`ifdef NF_RF_SCOREBOARD_EN
        rd_pend = '0;
`endif
        for (int i = 0; i < RD_PORTS; i++) begin
            rd_addr = ra[i*AW +: AW];
            if (!init_done || rd_addr == '0) begin
                rd[i*XLEN +: XLEN] = '0;
            end else if (we_b && rd_addr == wa_b) begin
                rd[i*XLEN +: XLEN] = wd_b;
            end else if (we_a && rd_addr == wa_a) begin
                rd[i*XLEN +: XLEN] = wd_a;
            end else begin
                rd[i*XLEN +: XLEN] = mem_q[rd_addr];
            end
`ifdef NF_RF_SCOREBOARD_EN
            // An in-flight load return retires the pending mark in the same cycle its data bypasses.
            rd_pend[i] = init_done && pend_q[rd_addr] && !(we_b && rd_addr == wa_b);
`endif
        end
    end

endmodule

// File: tb/tb_nf_reg_file_mp.sv
// tb/tb_nf_reg_file_mp.sv - scoreboard-style bench for nf_reg_file_mp (4 read ports)
module tb_nf_reg_file_mp;

    localparam int XLEN     = 32;
    localparam int REG_NUM  = 32;
    localparam int RD_PORTS = 4;
    localparam int AW       = 5;

    logic                     clk;
    logic                     resetn;
    logic [RD_PORTS*AW-1:0]   ra;
    logic [RD_PORTS*XLEN-1:0] rd;
    logic [AW-1:0]            wa_a, wa_b;
    logic [XLEN-1:0]          wd_a, wd_b;
    logic                     we_a, we_b;
    logic                     init_done;
`ifdef NF_RF_SCOREBOARD_EN
    logic                     pend_set;
    logic [AW-1:0]            pend_addr;
    logic [RD_PORTS-1:0]      rd_pend;
`endif

    nf_reg_file_mp #(
        .XLEN     (XLEN),
        .REG_NUM  (REG_NUM),
        .RD_PORTS (RD_PORTS)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ra        (ra),
        .rd        (rd),
        .wa_a      (wa_a),
        .wd_a      (wd_a),
        .we_a      (we_a),
        .wa_b      (wa_b),
        .wd_b      (wd_b),
        .we_b      (we_b),
        .init_done (init_done)
`ifdef NF_RF_SCOREBOARD_EN
        ,
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .rd_pend   (rd_pend)
`endif
    );

    typedef struct {
        logic            we_a;
        logic [AW-1:0]   wa_a;
        logic [XLEN-1:0] wd_a;
        logic            we_b;
        logic [AW-1:0]   wa_b;
        logic [XLEN-1:0] wd_b;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] e0;
        logic [XLEN-1:0] e1;
    } vec_t;

    int              total;
    int              bad;
    logic [XLEN-1:0] exp_q [$];
    logic [XLEN-1:0] model [REG_NUM];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int wea, input int waa, input int wda, input int web,
                                input int wab, input int wdb, input int r0, input int r1,
                                input int x0, input int x1);
        vec_t v;
        v.we_a = wea[0];  v.wa_a = AW'(waa);  v.wd_a = XLEN'(wda);
        v.we_b = web[0];  v.wa_b = AW'(wab);  v.wd_b = XLEN'(wdb);
        v.ra0  = AW'(r0); v.ra1  = AW'(r1);   v.e0   = XLEN'(x0);  v.e1 = XLEN'(x1);
        return v;
    endfunction

    task automatic set_idle();
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        ra   = '0;
`ifdef NF_RF_SCOREBOARD_EN
        pend_set = 1'b0; pend_addr = '0;
`endif
    endtask

    // Ports 2/3 mirror ports 0/1 so every vector also exercises port independence.
    task automatic drive_vec(input vec_t v);
        we_a = v.we_a; wa_a = v.wa_a; wd_a = v.wd_a;
        we_b = v.we_b; wa_b = v.wa_b; wd_b = v.wd_b;
        ra   = {v.ra1, v.ra0, v.ra1, v.ra0};
        exp_q.push_back(v.e0); exp_q.push_back(v.e1);
        exp_q.push_back(v.e0); exp_q.push_back(v.e1);
    endtask

    function automatic logic [XLEN-1:0] predict(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (we_b && a == wa_b) return wd_b;
        if (we_a && a == wa_a) return wd_a;
        return model[a];
    endfunction

    function automatic void model_update();
        if (we_b && wa_b != '0) model[wa_b] = wd_b;
        if (we_a && wa_a != '0 && !(we_b && wa_b == wa_a)) model[wa_a] = wd_a;
    endfunction

    task automatic test_reset();
        resetn = 1'b1;
        set_idle();
        #1 resetn = 1'b0;
        #1;
        total++;
        if (init_done !== 1'b0) begin
            bad++; $display("FAIL reset_init_done got=%b want=0", init_done);
        end
        total++;
        if (rd !== '0) begin
            bad++; $display("FAIL reset_rd got=%h want=0", rd);
        end
`ifdef NF_RF_SCOREBOARD_EN
        total++;
        if (rd_pend !== '0) begin
            bad++; $display("FAIL reset_rd_pend got=%b want=0", rd_pend);
        end
`endif
    endtask

    task automatic wait_clear(input string tag);
        for (int k = 0; k < REG_NUM - 1; k++) begin
            #1;
            total++;
            if (init_done !== 1'b0) begin
                bad++; $display("FAIL %s_busy cycle=%0d got=%b want=0", tag, k, init_done);
            end
            total++;
            if (rd[XLEN-1:0] !== '0) begin
                bad++; $display("FAIL %s_rd_zero cycle=%0d got=%h want=0", tag, k, rd[XLEN-1:0]);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (init_done !== 1'b1) begin
            bad++; $display("FAIL %s_done got=%b want=1", tag, init_done);
        end
    endtask

    task automatic test_clear();
        logic [XLEN-1:0] exp_v;
        @(negedge clk);
        we_a = 1'b1; wa_a = AW'(5); wd_a = 32'hAAAA;
        ra   = {RD_PORTS{AW'(5)}};
        resetn = 1'b1;
        wait_clear("clear");
        set_idle();
        for (int i = 0; i < REG_NUM; i++) model[i] = '0;
        for (int a = 0; a < REG_NUM; a++) begin
            @(negedge clk);
            ra = {RD_PORTS{AW'(a)}};
            for (int p = 0; p < RD_PORTS; p++) exp_q.push_back(predict(AW'(a)));
            #1;
            for (int p = 0; p < RD_PORTS; p++) begin
                exp_v = exp_q.pop_front();
                total++;
                if (rd[p*XLEN +: XLEN] !== exp_v) begin
                    bad++; $display("FAIL clear_read reg%0d port%0d got=%h want=%h", a, p, rd[p*XLEN +: XLEN], exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if (init_done !== 1'b0) begin
            bad++; $display("FAIL midreset_asserted got=%b want=0", init_done);
        end
        @(negedge clk);
        resetn = 1'b1;
        wait_clear("midreset");
    endtask

    task automatic run_table(input string tag, input vec_t vq [$]);
        logic [XLEN-1:0] exp_v;
        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            drive_vec(vq[k]);
            #1;
            for (int p = 0; p < RD_PORTS; p++) begin
                exp_v = exp_q.pop_front();
                total++;
                if (rd[p*XLEN +: XLEN] !== exp_v) begin
                    bad++; $display("FAIL %s step%0d port%0d got=%h want=%h", tag, k, p, rd[p*XLEN +: XLEN], exp_v);
                end
            end
            model_update();
        end
    endtask

    task automatic test_bypass();
        vec_t vq [$];
        vq.push_back(mk(1, 7, 'h5555, 0, 0, 0,      7, 12, 'h5555, 0));
        vq.push_back(mk(0, 7, 'h1234, 0, 0, 0,      7, 7,  'h5555, 'h5555));
        vq.push_back(mk(1, 7, 'h1234, 0, 0, 0,      7, 0,  'h1234, 0));
        vq.push_back(mk(1, 0, 'hFFFF, 0, 0, 0,      0, 7,  0,      'h1234));
        vq.push_back(mk(0, 0, 0,      1, 0, 'hEEEE, 0, 0,  0,      0));
        vq.push_back(mk(0, 12, 'h1111, 1, 12, 'hBEEF, 12, 7, 'hBEEF, 'h1234));
        vq.push_back(mk(1, 12, 'h2222, 0, 12, 'h3333, 12, 0, 'h2222, 0));
        vq.push_back(mk(0, 0, 0,      0, 0, 0,      12, 7, 'h2222, 'h1234));
        run_table("bypass", vq);
    endtask

    task automatic test_collision();
        vec_t vq [$];
        vq.push_back(mk(1, 9,  'h11, 1, 9,  'h22, 9,  9,  'h22, 'h22));
        vq.push_back(mk(0, 0,  0,    0, 0,  0,    9,  0,  'h22, 0));
        vq.push_back(mk(1, 10, 'hA0, 1, 11, 'hB0, 10, 11, 'hA0, 'hB0));
        vq.push_back(mk(0, 0,  0,    0, 0,  0,    10, 11, 'hA0, 'hB0));
        run_table("collision", vq);
    endtask

    task automatic test_port_independence();
        vec_t vq [$];
        vq.push_back(mk(0, 0, 0, 1, 3, 'hCAFE, 3, 3, 'hCAFE, 'hCAFE));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,      3, 3, 'hCAFE, 'hCAFE));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,      3, 9, 'hCAFE, 'h22));
        run_table("ports", vq);
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] exp_v;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            we_a = 1'($urandom_range(0, 1)); wa_a = AW'($urandom_range(0, 7)); wd_a = $urandom;
            we_b = 1'($urandom_range(0, 1)); wa_b = AW'($urandom_range(0, 7)); wd_b = $urandom;
            for (int p = 0; p < RD_PORTS; p++) ra[p*AW +: AW] = AW'($urandom_range(0, 7));
            for (int p = 0; p < RD_PORTS; p++) exp_q.push_back(predict(ra[p*AW +: AW]));
            #1;
            for (int p = 0; p < RD_PORTS; p++) begin
                exp_v = exp_q.pop_front();
                total++;
                if (rd[p*XLEN +: XLEN] !== exp_v) begin
                    bad++; $display("FAIL b2b cycle%0d port%0d got=%h want=%h", k, p, rd[p*XLEN +: XLEN], exp_v);
                end
            end
            model_update();
        end
        @(negedge clk);
        set_idle();
    endtask

`ifdef NF_RF_SCOREBOARD_EN
    task automatic test_scoreboard();
        logic [RD_PORTS-1:0] pq [$];
        logic [RD_PORTS-1:0] exp_p;
        //               set addr web wab ra0 ra1 exp(p1,p0)
        int tab [8][6] = '{'{1, 4, 0, 0, 4, 5, 0},
                           '{0, 0, 0, 0, 4, 5, 1},
                           '{0, 0, 1, 4, 4, 5, 0},
                           '{0, 0, 0, 0, 4, 5, 0},
                           '{1, 4, 1, 4, 4, 5, 0},
                           '{0, 0, 0, 0, 4, 5, 1},
                           '{1, 0, 0, 0, 0, 4, 2},
                           '{0, 0, 0, 0, 0, 4, 2}};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_idle();
            pend_set  = tab[k][0][0];
            pend_addr = AW'(tab[k][1]);
            we_b      = tab[k][2][0];
            wa_b      = AW'(tab[k][3]);
            wd_b      = XLEN'(32'h4400 + k);
            ra        = {AW'(tab[k][5]), AW'(tab[k][4]), AW'(tab[k][5]), AW'(tab[k][4])};
            pq.push_back({tab[k][6][1:0], tab[k][6][1:0]});
            #1;
            exp_p = pq.pop_front();
            total++;
            if (rd_pend !== exp_p) begin
                bad++; $display("FAIL scoreboard step%0d got=%b want=%b", k, rd_pend, exp_p);
            end
            model_update();
        end
        @(negedge clk);
        set_idle();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_clear();
        test_reset_mid_clear();
        for (int i = 0; i < REG_NUM; i++) model[i] = '0;
        test_bypass();
        test_collision();
        test_port_independence();
        test_back_to_back();
`ifdef NF_RF_SCOREBOARD_EN
        test_scoreboard();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nf_reg_file_mp.md
Name: nf_reg_file_mp

Overview:
Parametrised multi-port register file, the successor to the core's 2R1W register file.
- Configurable data width, register count and read-port count.
- Two write ports: ALU writeback (port A) and load-return (port B).
- Hardware clear sequence after reset.
- Write-enable-qualified bypass with defined port priority.
- Sits in the core between decode (read) and writeback (write).

Parameters:
XLEN, 32, data width in bits
REG_NUM, 32, number of registers; power of two, >= 2
RD_PORTS, 2, number of read ports, 1..4
AW, $clog2(REG_NUM), address width (derived; not overridden)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
ra  input  RD_PORTS*AW  packed read addresses; port i at [i*AW +: AW]
rd  output  RD_PORTS*XLEN  packed read data; port i at [i*XLEN +: XLEN]
wa_a  input  AW  write address, port A
wd_a  input  XLEN  write data, port A
we_a  input  1  write enable, port A
wa_b  input  AW  write address, port B
wd_b  input  XLEN  write data, port B
we_b  input  1  write enable, port B
init_done  output  1  high once the clear sequence has finished
pend_set  input  1  scoreboard set strobe (only with NF_RF_SCOREBOARD_EN)
pend_addr  input  AW  register to mark pending (only with NF_RF_SCOREBOARD_EN)
rd_pend  output  RD_PORTS  per-read-port pending flag (only with NF_RF_SCOREBOARD_EN)

Behaviour:
- Reset (resetn low, asynchronous):
  - FSM enters CLEAR and the clear counter goes to 1.
  - init_done = 0; rd_pend = 0.
  - Array contents need no reset flops.
- FSM states:
  - CLEAR: writes 0 to reg[cnt] each cycle, cnt increments.
  - CLEAR -> READY on the cycle reg[REG_NUM-1] is written.
  - READY is terminal until the next reset.
  - Clear takes REG_NUM-1 cycles after resetn deasserts; init_done rises on the following clock edge.
- During CLEAR:
  - we_a and we_b are ignored.
  - All rd outputs read 0, with no bypass.
  - resetn assertion mid-clear restarts the sequence at cnt = 1.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0 regardless of bypass.
- Writes (READY) take effect at posedge clk.
  - wa_a == wa_b with both enables high: port B's data is stored and port A is dropped.
- Reads are combinational, with zero-cycle bypass evaluated in priority order:
  1. ra == 0 gives 0.
  2. we_b && ra == wa_b gives wd_b.
  3. we_a && ra == wa_a gives wd_a.
  4. Otherwise reg[ra].
- Bypass only fires when the matching enable is high; an address match with the enable low reads the array.
- All read ports are independent; the same address on several ports returns identical data.

Optional Feature:
Macro: NF_RF_SCOREBOARD_EN
- With the macro defined:
  - A REG_NUM-bit pending vector, all 0 on reset and during CLEAR.
  - pend_set sets bit pend_addr at the clock edge.
  - A we_b write clears bit wa_b.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 never sets.
  - rd_pend[i] = pending[ra_i], combinational.
  - A we_b write to the same address in the current cycle masks rd_pend[i] to 0, consistent with the bypass.
- Without the macro: pend_set, pend_addr and rd_pend are absent; no pending state.

Decomposition:
- Package nf_rf_pkg:
  - Defaults NF_RF_XLEN = 32, NF_RF_REG_NUM = 32, NF_RF_RD_PORTS = 2.
  - Typedef rf_state_e {RF_CLEAR, RF_READY}.
- Sub-module nf_rf_init_fsm:
  - Owns the state register and clear counter.
  - Outputs clr_we, clr_addr and init_done.
- The top level holds the array, the write muxes, the bypass and the scoreboard.

Test Plan:
1. Clear sequence, REG_NUM = 32: release resetn -> init_done = 0 for 31 cycles, 1 on the next edge; all 31 registers then read 0; we_a with wa_a = 5, wd_a = 0xAAAA during CLEAR has no effect, so reg5 reads 0 after clear.
2. Reset mid-clear: assert resetn at cycle 10 of clear -> init_done stays 0; after release, another 31 cycles before init_done = 1.
3. Bypass and x0:
   - we_a = 1, wa_a = 7, wd_a = 0x1234, ra0 = 7 -> rd0 = 0x1234 in the same cycle.
   - we_a = 0, wa_a = 7, wd_a = 0x1234, ra0 = 7 -> rd0 = stored reg7 value, not 0x1234.
   - wa_a = 0, wd_a = 0xFFFF, ra0 = 0 -> rd0 = 0 and reg0 stays 0.
4. Write-port collision: we_a = we_b = 1, wa_a = wa_b = 9, wd_a = 0x11, wd_b = 0x22 -> same-cycle read gives 0x22; next cycle reg9 = 0x22.
5. Port independence: RD_PORTS = 4, all ports read address 3 holding 0xCAFE -> all four rd = 0xCAFE.
6. Scoreboard (macro on):
   - pend_set with pend_addr = 4 -> next cycle rd_pend[0] = 1 for ra0 = 4.
   - we_b with wa_b = 4 -> rd_pend[0] = 0 that same cycle and thereafter.
   - pend_set and we_b both on address 4 in one cycle -> bit stays 1.
